// File: rtl/jpeg_fdct_x.sv
// Forward 8-point 1D DCT row stage: ping-pong row banks feed an engine that
// produces one coefficient per cycle through a two-register multiply/add pipeline.
module jpeg_fdct_x #(
  parameter int unsigned OUT_SHIFT = 13
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [15:0] inport_data_i,
  input  logic [5:0]  inport_idx_i,
  output logic        outport_valid_o,
  output logic [15:0] outport_data_o,
  output logic [5:0]  outport_idx_o
);
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 32;
  localparam int unsigned NPTS = 8;
  localparam int RND = 1 << (OUT_SHIFT - 1);
  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Cosine table entry T[k][n]: fold (2n+1)k mod 32 onto C0..C8 with sign.
  function automatic logic signed [DW-1:0] coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] m;
    logic neg;
    logic signed [DW-1:0] mag;
    m = 5'({n, 1'b1}) * 5'(k);
    if (m > 5'd16) m = 5'(6'd32 - {1'b0, m});
    neg = (m > 5'd8);
    if (neg) m = 5'd16 - m;
    case (m)
      5'd0:    mag = 16'sd2896;
      5'd1:    mag = 16'sd4017;
      5'd2:    mag = 16'sd3784;
      5'd3:    mag = 16'sd3406;
      5'd4:    mag = 16'sd2896;
      5'd5:    mag = 16'sd2276;
      5'd6:    mag = 16'sd1567;
      5'd7:    mag = 16'sd799;
      default: mag = '0;
    endcase
    return neg ? -mag : mag;
  endfunction

  logic [DW-1:0] r_bank [2][NPTS];
  logic          r_fill_sel;
  logic          w_fill_sel;
  logic [2:0]    w_col;
  logic [2:0]    w_row;
  logic          w_start;

  assign w_col      = inport_idx_i[2:0];
  assign w_row      = inport_idx_i[5:3];
  assign w_fill_sel = img_start_i ? 1'b0 : r_fill_sel;
  assign w_start    = inport_valid_i && (w_col == 3'd7);

  // Row banks; a new image clears them before the same-cycle sample lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++)
        for (int n = 0; n < int'(NPTS); n++) r_bank[1'(b)][3'(n)] <= '0;
      r_fill_sel <= 1'b0;
    end else begin
      if (img_start_i) begin
        for (int b = 0; b < 2; b++)
          for (int n = 0; n < int'(NPTS); n++) r_bank[1'(b)][3'(n)] <= '0;
        r_fill_sel <= 1'b0;
      end
      if (inport_valid_i) begin
        r_bank[w_fill_sel][w_col] <= inport_data_i;
        if (w_start) r_fill_sel <= ~w_fill_sel;
      end
    end
  end

  state_t     r_state, w_state_nx;
  logic [2:0] r_k, w_k_nx;
  logic       r_eng_bank, w_eng_bank_nx;
  logic [2:0] r_eng_row, w_eng_row_nx;
  logic       r_pend, w_pend_nx;
  logic       r_pend_bank, w_pend_bank_nx;
  logic [2:0] r_pend_row, w_pend_row_nx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_eng_bank  <= 1'b0;
      r_eng_row   <= '0;
      r_pend      <= 1'b0;
      r_pend_bank <= 1'b0;
      r_pend_row  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_k         <= w_k_nx;
      r_eng_bank  <= w_eng_bank_nx;
      r_eng_row   <= w_eng_row_nx;
      r_pend      <= w_pend_nx;
      r_pend_bank <= w_pend_bank_nx;
      r_pend_row  <= w_pend_row_nx;
    end
  end

  // Engine sequencing; a start at k==7 chains into k=0 with no bubble.
  always_comb begin
    w_state_nx     = r_state;
    w_k_nx         = r_k;
    w_eng_bank_nx  = r_eng_bank;
    w_eng_row_nx   = r_eng_row;
    w_pend_nx      = r_pend;
    w_pend_bank_nx = r_pend_bank;
    w_pend_row_nx  = r_pend_row;
    if (img_start_i) begin
      w_pend_nx  = 1'b0;
      w_state_nx = ST_IDLE;
      if (w_start) begin
        w_state_nx    = ST_RUN;
        w_k_nx        = '0;
        w_eng_bank_nx = w_fill_sel;
        w_eng_row_nx  = w_row;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            w_state_nx    = ST_RUN;
            w_k_nx        = '0;
            w_eng_bank_nx = w_fill_sel;
            w_eng_row_nx  = w_row;
          end
        end
        ST_RUN: begin
          w_k_nx = 3'(r_k + 3'd1);
          if (r_k == 3'd7) begin
            if (r_pend) begin
              w_eng_bank_nx  = r_pend_bank;
              w_eng_row_nx   = r_pend_row;
              w_pend_nx      = w_start;
              w_pend_bank_nx = w_fill_sel;
              w_pend_row_nx  = w_row;
            end else if (w_start) begin
              w_eng_bank_nx = w_fill_sel;
              w_eng_row_nx  = w_row;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else if (w_start) begin
            w_pend_nx      = 1'b1;
            w_pend_bank_nx = w_fill_sel;
            w_pend_row_nx  = w_row;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  logic signed [AW-1:0] w_prod [NPTS];
  logic signed [AW-1:0] r_prod [NPTS];
  logic                 r_s1_valid;
  logic [5:0]           r_s1_idx;

  always_comb begin
    for (int n = 0; n < int'(NPTS); n++)
      w_prod[3'(n)] = AW'($signed(r_bank[r_eng_bank][3'(n)])) * AW'(coef(r_k, 3'(n)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < int'(NPTS); n++) r_prod[3'(n)] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= (r_state == ST_RUN) && !img_start_i;
      if (r_state == ST_RUN) begin
        for (int n = 0; n < int'(NPTS); n++) r_prod[3'(n)] <= w_prod[3'(n)];
        r_s1_idx <= {r_eng_row, r_k};
      end
    end
  end

  logic signed [AW-1:0] w_acc, w_shift;
  logic signed [DW-1:0] w_sat;

  // Adder tree, round-half-up, arithmetic shift and saturation.
  always_comb begin
    w_acc = '0;
    for (int n = 0; n < int'(NPTS); n++) w_acc = w_acc + r_prod[3'(n)];
    w_shift = (w_acc + AW'(RND)) >>> OUT_SHIFT;
    if (w_shift > SAT_MAX)      w_sat = 16'sh7fff;
    else if (w_shift < SAT_MIN) w_sat = 16'sh8000;
    else                        w_sat = w_shift[DW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outport_valid_o <= 1'b0;
      outport_data_o  <= '0;
      outport_idx_o   <= '0;
    end else if (img_start_i) begin
      outport_valid_o <= 1'b0;
    end else begin
      outport_valid_o <= r_s1_valid;
      if (r_s1_valid) begin
        outport_data_o <= w_sat;
        outport_idx_o  <= r_s1_idx;
      end
    end
  end
endmodule

// File: tb/tb_jpeg_fdct_x.sv
// Scoreboard bench for jpeg_fdct_x: a floating-point cosine model predicts each
// coefficient and the cycle it must appear on.
module tb_jpeg_fdct_x;
  logic        clk = 1'b0;
  logic        rst, img_start, in_valid;
  logic [15:0] in_data;
  logic [5:0]  in_idx;
  logic        out_valid;
  logic [15:0] out_data;
  logic [5:0]  out_idx;

  always #5 clk = ~clk;

  jpeg_fdct_x #(.OUT_SHIFT(13)) dut (
    .clk_i(clk), .rst_i(rst), .img_start_i(img_start),
    .inport_valid_i(in_valid), .inport_data_i(in_data), .inport_idx_i(in_idx),
    .outport_valid_o(out_valid), .outport_data_o(out_data), .outport_idx_o(out_idx)
  );

  typedef struct { int cyc; logic [5:0] idx; logic [15:0] data; } ent_t;
  ent_t exp_q[$];
  ent_t cap_q[$];
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int x [8];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_valid === 1'b1) cap_q.push_back('{cyc, out_idx, out_data});

  function automatic int coef(int k, int n);
    real c;
    if (k == 0) return 2896;
    c = 4096.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    return (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
  endfunction

  function automatic logic [15:0] model(int k);
    longint acc = 0;
    for (int n = 0; n < 8; n++) acc += longint'(x[n]) * longint'(coef(k, n));
    acc = (acc + 4096) >>> 13;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic fill_const(input int v);
    for (int n = 0; n < 8; n++) x[n] = v;
  endtask

  task automatic fill_rand();
    logic signed [15:0] s;
    for (int n = 0; n < 8; n++) begin s = 16'($urandom); x[n] = int'(s); end
  endtask

  task automatic send_row(input int row, input int gap, input bit push, output int acc);
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'(x[c]); in_idx = {3'(row), 3'(c)};
      if (c == 7) begin
        acc = cyc + 1;
        if (push)
          for (int k = 0; k < 8; k++) exp_q.push_back('{acc + 2 + k, {3'(row), 3'(k)}, model(k)});
      end
      for (int g = 0; g < gap; g++) begin @(negedge clk); in_valid = 1'b0; end
    end
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk); in_valid = 1'b0;
    while (cap_q.size() < exp_q.size() && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; img_start = 1'b0; in_valid = 1'b0; in_data = '0; in_idx = '0;
    repeat (3) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", out_data); end
    vectors++; if (out_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dc(input string name);
    ent_t e, a; int acc;
    fill_const(100);
    send_row(0, 0, 1'b1, acc);
    wait_out();
    vectors++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, cap_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_q.pop_front();
      vectors++;
      if (a.cyc !== e.cyc || a.idx !== e.idx || a.data !== e.data || a.data !== ((a.idx[2:0] == 3'd0) ? 16'd283 : 16'd0)) begin
        errors++;
        $display("FAIL %s_out: cyc/idx/data got %0d/%0d/%0d want %0d/%0d/%0d", name, a.cyc, a.idx, $signed(a.data), e.cyc, e.idx, $signed(e.data));
      end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_impulse();
    ent_t e, a; int acc;
    fill_const(0); x[0] = 1000;
    send_row(2, 0, 1'b1, acc);
    wait_out();
    vectors++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL impulse_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_q.pop_front();
      vectors++;
      if (a.cyc !== e.cyc || a.idx !== e.idx || a.data !== e.data ||
          (a.idx == 6'd16 && a.data !== 16'd354) || (a.idx == 6'd17 && a.data !== 16'd490)) begin
        errors++;
        $display("FAIL impulse_out: cyc/idx/data got %0d/%0d/%0d want %0d/%0d/%0d", a.cyc, a.idx, $signed(a.data), e.cyc, e.idx, $signed(e.data));
      end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_saturation(input int v, input logic [15:0] k0);
    ent_t e, a; int acc;
    fill_const(v);
    send_row(1, 0, 1'b1, acc);
    wait_out();
    vectors++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_q.pop_front();
      vectors++;
      if (a.cyc !== e.cyc || a.idx !== e.idx || a.data !== ((a.idx[2:0] == 3'd0) ? k0 : 16'd0)) begin
        errors++;
        $display("FAIL sat_out: cyc/idx/data got %0d/%0d/%0d want %0d/%0d/%0d", a.cyc, a.idx, $signed(a.data), e.cyc, e.idx, $signed(e.data));
      end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_stream(input string name, input int gap, input int seed_rows [2][8]);
    ent_t e, a; int acc;
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 8; n++) x[n] = seed_rows[r][n];
      send_row(r, gap, 1'b1, acc);
    end
    wait_out();
    vectors++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, cap_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_q.pop_front();
      vectors++;
      if (a.cyc !== e.cyc || a.idx !== e.idx || a.data !== e.data) begin
        errors++;
        $display("FAIL %s_out: cyc/idx/data got %0d/%0d/%0d want %0d/%0d/%0d", name, a.cyc, a.idx, $signed(a.data), e.cyc, e.idx, $signed(e.data));
      end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_img_start();
    ent_t e, a; int acc;
    fill_rand();
    send_row(6, 0, 1'b0, acc);
    exp_q.push_back('{acc + 2, 6'd48, model(0)});
    exp_q.push_back('{acc + 3, 6'd49, model(1)});
    @(negedge clk); in_valid = 1'b0;
    while (cyc < acc + 3) @(negedge clk);
    img_start = 1'b1;
    @(negedge clk); img_start = 1'b0;
    repeat (12) @(negedge clk);
    fill_rand();
    send_row(5, 0, 1'b1, acc);
    wait_out();
    vectors++;
    if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front(); a = cap_q.pop_front();
      vectors++;
      if (a.cyc !== e.cyc || a.idx !== e.idx || a.data !== e.data) begin
        errors++;
        $display("FAIL abort_out: cyc/idx/data got %0d/%0d/%0d want %0d/%0d/%0d", a.cyc, a.idx, $signed(a.data), e.cyc, e.idx, $signed(e.data));
      end
    end
    exp_q.delete(); cap_q.delete();
  endtask

  task automatic test_mid_reset();
    fill_const(77);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 16'(x[c]); in_idx = {3'd4, 3'(c)};
    end
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 16'd0) begin errors++; $display("FAIL midrst_data: got %0d want 0", out_data); end
    vectors++; if (out_idx !== 6'd0) begin errors++; $display("FAIL midrst_idx: got %0d want 0", out_idx); end
    cap_q.delete();
    test_dc("dc_after_rst");
  endtask

  initial begin
    int rows [2][8];
    logic signed [15:0] s;
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < 8; n++) begin s = 16'($urandom); rows[r][n] = int'(s); end
    test_reset();
    test_dc("dc");
    test_impulse();
    test_saturation(32767, 16'h7fff);
    test_saturation(-32768, 16'h8000);
    test_stream("b2b", 0, rows);
    test_stream("gapped", 1, rows);
    test_img_start();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
